// File: rtl/demux116_deser.sv
// demux116_deser: 1-to-16 serial-to-parallel deserializer with a fill register and an output register; DEMUX_PARITY_EN adds an even-parity slot to each frame.
// A word reaches y_o one cycle after its last bit; a word completing while y_o is still unconsumed is dropped and overrun_o is set.
module demux116_deser #(
  parameter int NSLOT = 16,
  parameter int SELW  = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             din_i,
  input  logic             din_valid_i,
  input  logic             sof_i,
  output logic [NSLOT-1:0] y_o,
  output logic             y_valid_o,
  input  logic             y_ready_i,
  output logic [SELW-1:0]  slot_o,
  output logic             busy_o,
  output logic             overrun_o,
  output logic             short_o,
  output logic             perr_o,
  input  logic             clr_i
);

`ifdef DEMUX_PARITY_EN
  localparam int CNTW     = SELW + 1;
  localparam int LASTSLOT = NSLOT;
`else
  localparam int CNTW     = SELW;
  localparam int LASTSLOT = NSLOT - 1;
`endif
  localparam logic [CNTW-1:0] LAST = CNTW'(LASTSLOT);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CNTW-1:0]  slot_q, slot_d;
  logic [NSLOT-1:0] fill_q, fill_d;
  logic [NSLOT-1:0] y_q, y_d;
  logic             done_q, done_d;
  logic             y_valid_q, y_valid_d;
  logic             overrun_q, overrun_d;
  logic             short_q, short_d;
  logic             perr_q, perr_d;
  logic             wr_sof, wr_data, last_bit, par_bad;

  assign wr_sof   = din_valid_i & sof_i;
  assign wr_data  = din_valid_i & ~sof_i & (state_q == FILL);
  assign last_bit = wr_data & (slot_q == LAST);

`ifdef DEMUX_PARITY_EN
  // fill_q already holds slots 0..NSLOT-1 when the parity bit arrives
  assign par_bad = last_bit & (din_i != ^fill_q);
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (wr_sof) begin
      state_d = FILL;
    end else if (last_bit) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    busy_o = (state_q == FILL);
  end

  always_comb begin
    slot_d = slot_q;
    fill_d = fill_q;
    done_d = last_bit;
    if (wr_sof) begin
      fill_d[0] = din_i;
      slot_d    = CNTW'(1);
    end else if (wr_data) begin
`ifdef DEMUX_PARITY_EN
      if (!slot_q[SELW])
`endif
        fill_d[slot_q[SELW-1:0]] = din_i;
      slot_d = last_bit ? '0 : slot_q + CNTW'(1);
    end
  end

  // Set events win over a same-cycle clear of the sticky flags
  always_comb begin
    y_d       = y_q;
    y_valid_d = y_valid_q;
    overrun_d = overrun_q & ~clr_i;
    short_d   = (short_q & ~clr_i) | (wr_sof & (state_q == FILL));
    perr_d    = (perr_q & ~clr_i) | par_bad;
    if (done_q) begin
      if (!y_valid_q || y_ready_i) begin
        y_d       = fill_q;
        y_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (y_valid_q && y_ready_i) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q    <= '0;
      fill_q    <= '0;
      done_q    <= 1'b0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      short_q   <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      slot_q    <= slot_d;
      fill_q    <= fill_d;
      done_q    <= done_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      overrun_q <= overrun_d;
      short_q   <= short_d;
      perr_q    <= perr_d;
    end
  end

  assign y_o       = y_q;
  assign y_valid_o = y_valid_q;
  assign slot_o    = slot_q[SELW-1:0];
  assign overrun_o = overrun_q;
  assign short_o   = short_q;
  assign perr_o    = perr_q;

endmodule
